// File: rtl/ttw_mem_bridge_if.sv
// Walker request/response and downstream memory request/response signals of ttw_mem_bridge.
// The slave modport is the bridge's view; master is the surrounding environment.
interface ttw_mem_bridge_if #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned MCN_W  = 58,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned TAG_W  = 2
);
    logic              mem_req_i_valid;
    logic              mem_req_i_ready;
    logic [IDX_W-1:0]  mem_req_i_bits_idx;
    logic [MCN_W-1:0]  mem_req_i_bits_mcn;
    logic              mem_res_o_valid;
    logic              mem_res_o_ready;
    logic [IDX_W-1:0]  mem_res_o_bits_idx;
    logic [DATA_W-1:0] mem_res_o_bits_data;
    logic              mrq_o_valid;
    logic              mrq_o_ready;
    logic [MCN_W+5:0]  mrq_o_bits_addr;
    logic [TAG_W-1:0]  mrq_o_bits_tag;
    logic              mrs_i_valid;
    logic [TAG_W-1:0]  mrs_i_bits_tag;
    logic [DATA_W-1:0] mrs_i_bits_data;

    modport slave (
        input  mem_req_i_valid, mem_req_i_bits_idx, mem_req_i_bits_mcn,
        output mem_req_i_ready,
        output mem_res_o_valid, mem_res_o_bits_idx, mem_res_o_bits_data,
        input  mem_res_o_ready,
        output mrq_o_valid, mrq_o_bits_addr, mrq_o_bits_tag,
        input  mrq_o_ready,
        input  mrs_i_valid, mrs_i_bits_tag, mrs_i_bits_data
    );

    modport master (
        output mem_req_i_valid, mem_req_i_bits_idx, mem_req_i_bits_mcn,
        input  mem_req_i_ready,
        input  mem_res_o_valid, mem_res_o_bits_idx, mem_res_o_bits_data,
        output mem_res_o_ready,
        input  mrq_o_valid, mrq_o_bits_addr, mrq_o_bits_tag,
        output mrq_o_ready,
        output mrs_i_valid, mrs_i_bits_tag, mrs_i_bits_data
    );
endinterface

// File: rtl/ttw_mem_bridge.sv
// Table-walker to memory bridge: tags line reads with a reserved slot, buffers
// out-of-order responses and returns them to the walker in arrival order.
module ttw_mem_bridge #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned MCN_W  = 58,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned DEPTH  = 4
) (
    input  logic            clock,
    input  logic            reset,
    ttw_mem_bridge_if.slave bus,
    output logic            busy_o,
    output logic            err_o
);
    localparam int unsigned TAG_W = $clog2(DEPTH);

    typedef enum logic [1:0] {SlotFree, SlotPend, SlotDone} slot_e;

    slot_e             slot_q [DEPTH];
    slot_e             slot_d [DEPTH];
    logic [IDX_W-1:0]  idx_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [TAG_W-1:0]  fifo_q [DEPTH];
    logic [TAG_W:0]    rd_ptr_q, wr_ptr_q;
    logic              mrq_valid_q;
    logic [MCN_W+5:0]  mrq_addr_q;
    logic [TAG_W-1:0]  mrq_tag_q;
    logic              err_q;

    logic              any_free, all_free, accept, hit, pop, fifo_empty;
    logic [TAG_W-1:0]  free_tag, head;

    // Descending scan so the lowest-numbered free slot wins.
    always_comb begin
        any_free = 1'b0;
        all_free = 1'b1;
        free_tag = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slot_q[i] == SlotFree) begin
                any_free = 1'b1;
                free_tag = TAG_W'(i);
            end else begin
                all_free = 1'b0;
            end
        end
    end

    assign fifo_empty = (rd_ptr_q == wr_ptr_q);
    assign head       = fifo_q[rd_ptr_q[TAG_W-1:0]];
    assign accept     = bus.mem_req_i_valid && bus.mem_req_i_ready;
    assign hit        = bus.mrs_i_valid && (slot_q[bus.mrs_i_bits_tag] == SlotPend);
    assign pop        = !fifo_empty && bus.mem_res_o_ready;

    assign bus.mem_req_i_ready     = !reset && any_free && (!mrq_valid_q || bus.mrq_o_ready);
    assign bus.mem_res_o_valid     = !fifo_empty;
    assign bus.mem_res_o_bits_idx  = idx_q[head];
    assign bus.mem_res_o_bits_data = data_q[head];
    assign bus.mrq_o_valid         = mrq_valid_q;
    assign bus.mrq_o_bits_addr     = mrq_addr_q;
    assign bus.mrq_o_bits_tag      = mrq_tag_q;
    assign busy_o                  = !all_free || mrq_valid_q;
    assign err_o                   = err_q;

    // Accept targets a FREE slot, a hit a PEND slot, a pop a DONE slot: never the same one.
    always_comb begin
        slot_d = slot_q;
        if (accept) slot_d[free_tag] = SlotPend;
        if (hit)    slot_d[bus.mrs_i_bits_tag] = SlotDone;
        if (pop)    slot_d[head] = SlotFree;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= SlotFree;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            mrq_valid_q <= 1'b0;
            mrq_addr_q  <= '0;
            mrq_tag_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            slot_q <= slot_d;
            if (hit) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (accept) begin
                mrq_valid_q <= 1'b1;
                mrq_addr_q  <= {bus.mem_req_i_bits_mcn, 6'b0};
                mrq_tag_q   <= free_tag;
            end else if (bus.mrq_o_ready) begin
                mrq_valid_q <= 1'b0;
            end
            if (bus.mrs_i_valid && !hit) err_q <= 1'b1;
        end
    end

    // Payload storage needs no reset: slot state and FIFO pointers gate every read.
    always_ff @(posedge clock) begin
        if (accept) idx_q[free_tag] <= bus.mem_req_i_bits_idx;
        if (hit) begin
            data_q[bus.mrs_i_bits_tag]      <= bus.mrs_i_bits_data;
            fifo_q[wr_ptr_q[TAG_W-1:0]] <= bus.mrs_i_bits_tag;
        end
    end
endmodule

// File: tb/tb_ttw_mem_bridge.sv
// Bench for ttw_mem_bridge: directed scenarios then random traffic, checked against a
// slot/queue reference model with a scoreboard monitor on both output handshakes.
module tb_ttw_mem_bridge;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned MCN_W  = 58;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned TAG_W  = 2;

    typedef logic [DATA_W-1:0] wide_t;

    logic clock = 1'b0;
    logic reset;
    logic busy_o, err_o;

    ttw_mem_bridge_if #(.IDX_W(IDX_W), .MCN_W(MCN_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    ttw_mem_bridge #(.IDX_W(IDX_W), .MCN_W(MCN_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .busy_o (busy_o),
        .err_o  (err_o)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input wide_t got, input wide_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: slot 0=free, 1=awaiting memory, 2=data held for return.
    int               m_state [DEPTH];
    logic [IDX_W-1:0] m_idx   [DEPTH];
    wide_t            m_data  [DEPTH];
    int               m_ret[$];
    bit               m_pend;
    logic [MCN_W+5:0] m_addr;
    logic [TAG_W-1:0] m_tag;
    bit               m_err;

    logic [MCN_W+5:0] exp_addr_q[$];
    logic [TAG_W-1:0] exp_tag_q[$];
    logic [IDX_W-1:0] exp_idx_q[$];
    wide_t            exp_data_q[$];

    always @(negedge clock) begin : model
        bit any_free, exp_ready, acc, fire, hit, pop, bsy;
        int free_t;
        if (reset) begin
            chk("ready_in_reset", wide_t'(bus.mem_req_i_ready), wide_t'(0));
            for (int i = 0; i < DEPTH; i++) m_state[i] = 0;
            m_ret.delete();
            m_pend = 0;
            m_err  = 0;
            exp_addr_q.delete();
            exp_tag_q.delete();
            exp_idx_q.delete();
            exp_data_q.delete();
        end else begin
            any_free = 0;
            free_t   = 0;
            bsy      = m_pend;
            for (int i = 0; i < DEPTH; i++) begin
                if (m_state[i] == 0 && !any_free) begin
                    any_free = 1;
                    free_t   = i;
                end
                if (m_state[i] != 0) bsy = 1;
            end
            exp_ready = any_free && (!m_pend || bus.mrq_o_ready);
            chk("req_ready", wide_t'(bus.mem_req_i_ready), wide_t'(exp_ready));
            chk("mrq_valid", wide_t'(bus.mrq_o_valid), wide_t'(m_pend));
            if (m_pend) begin
                chk("mrq_addr_hold", wide_t'(bus.mrq_o_bits_addr), wide_t'(m_addr));
                chk("mrq_tag_hold", wide_t'(bus.mrq_o_bits_tag), wide_t'(m_tag));
            end
            chk("res_valid", wide_t'(bus.mem_res_o_valid), wide_t'(m_ret.size() != 0));
            if (m_ret.size() != 0) begin
                chk("res_idx_hold", wide_t'(bus.mem_res_o_bits_idx), wide_t'(m_idx[m_ret[0]]));
                chk("res_data_hold", bus.mem_res_o_bits_data, m_data[m_ret[0]]);
            end
            chk("busy", wide_t'(busy_o), wide_t'(bsy));
            chk("err", wide_t'(err_o), wide_t'(m_err));

            acc  = bus.mem_req_i_valid && exp_ready;
            fire = m_pend && bus.mrq_o_ready;
            hit  = bus.mrs_i_valid && m_state[bus.mrs_i_bits_tag] == 1;
            pop  = (m_ret.size() != 0) && bus.mem_res_o_ready;
            if (fire) m_pend = 0;
            if (pop) begin
                m_state[m_ret[0]] = 0;
                void'(m_ret.pop_front());
            end
            if (acc) begin
                m_state[free_t] = 1;
                m_idx[free_t]   = bus.mem_req_i_bits_idx;
                m_pend          = 1;
                m_addr          = {bus.mem_req_i_bits_mcn, 6'b0};
                m_tag           = TAG_W'(free_t);
                exp_addr_q.push_back(m_addr);
                exp_tag_q.push_back(m_tag);
            end
            if (hit) begin
                m_state[bus.mrs_i_bits_tag] = 2;
                m_data[bus.mrs_i_bits_tag]  = bus.mrs_i_bits_data;
                m_ret.push_back(int'(bus.mrs_i_bits_tag));
                exp_idx_q.push_back(m_idx[bus.mrs_i_bits_tag]);
                exp_data_q.push_back(bus.mrs_i_bits_data);
            end else if (bus.mrs_i_valid) begin
                m_err = 1;
            end
        end
    end

    logic [MCN_W+5:0] last_addr;
    logic [TAG_W-1:0] last_tag;
    logic [IDX_W-1:0] res_hist[$];

    always @(negedge clock) begin : monitor
        #1;
        if (!reset) begin
            if (bus.mrq_o_valid && bus.mrq_o_ready) begin
                last_addr = bus.mrq_o_bits_addr;
                last_tag  = bus.mrq_o_bits_tag;
                if (exp_addr_q.size() == 0) begin
                    chk("mrq_unexpected", wide_t'(bus.mrq_o_valid), wide_t'(0));
                end else begin
                    chk("mrq_addr", wide_t'(bus.mrq_o_bits_addr), wide_t'(exp_addr_q.pop_front()));
                    chk("mrq_tag", wide_t'(bus.mrq_o_bits_tag), wide_t'(exp_tag_q.pop_front()));
                end
            end
            if (bus.mem_res_o_valid && bus.mem_res_o_ready) begin
                res_hist.push_back(bus.mem_res_o_bits_idx);
                if (exp_idx_q.size() == 0) begin
                    chk("res_unexpected", wide_t'(bus.mem_res_o_valid), wide_t'(0));
                end else begin
                    chk("res_idx", wide_t'(bus.mem_res_o_bits_idx), wide_t'(exp_idx_q.pop_front()));
                    chk("res_data", bus.mem_res_o_bits_data, exp_data_q.pop_front());
                end
            end
        end
    end

    // Downstream memory: remembers issued tags so it can answer them later.
    int mem_q[$];
    always @(negedge clock) begin : memory
        if (reset) mem_q.delete();
        else if (bus.mrq_o_valid && bus.mrq_o_ready) mem_q.push_back(int'(bus.mrq_o_bits_tag));
    end

    function automatic wide_t rnd_data();
        wide_t d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.mem_req_i_valid = 1'b0;
        bus.mrs_i_valid     = 1'b0;
        bus.mrq_o_ready     = 1'b1;
        bus.mem_res_o_ready = 1'b1;
    endtask

    task automatic req(input int i, input logic [MCN_W-1:0] m);
        bus.mem_req_i_valid    = 1'b1;
        bus.mem_req_i_bits_idx = IDX_W'(i);
        bus.mem_req_i_bits_mcn = m;
    endtask

    task automatic send(input int t, input wide_t d);
        int k = -1;
        for (int i = 0; i < mem_q.size(); i++) if (k < 0 && mem_q[i] == t) k = i;
        if (k >= 0) mem_q.delete(k);
        bus.mrs_i_valid     = 1'b1;
        bus.mrs_i_bits_tag  = TAG_W'(t);
        bus.mrs_i_bits_data = d;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while (n < 200 && busy_o !== 1'b0) begin
            if (mem_q.size() > 0) send(mem_q[0], rnd_data());
            else bus.mrs_i_valid = 1'b0;
            step();
            n++;
        end
        idle();
        chk("drain_idle", wide_t'(busy_o), wide_t'(0));
    endtask

    int order[4] = '{2, 0, 3, 1};

    initial begin
        int base;
        reset = 1'b1;
        idle();
        bus.mem_req_i_bits_idx = '0;
        bus.mem_req_i_bits_mcn = '0;
        bus.mrs_i_bits_tag     = '0;
        bus.mrs_i_bits_data    = '0;
        repeat (2) step();
        reset = 1'b0;
        step();

        // Single read.
        req(3, 58'h1234);
        step();
        idle();
        step();
        send(0, rnd_data());
        step();
        idle();
        repeat (2) step();
        chk("single_addr", wide_t'(last_addr), wide_t'(64'h48d00));
        chk("single_tag", wide_t'(last_tag), wide_t'(0));
        chk("single_idx", wide_t'(res_hist[$]), wide_t'(3));

        // Out-of-order responses come back in arrival order.
        for (int i = 0; i < 4; i++) begin
            req(i, MCN_W'({$urandom, $urandom}));
            step();
        end
        idle();
        step();
        base = res_hist.size();
        for (int k = 0; k < 4; k++) begin
            send(order[k], rnd_data());
            step();
        end
        idle();
        repeat (3) step();
        for (int k = 0; k < 4; k++)
            chk("ooo_order", wide_t'(res_hist[base + k]), wide_t'(order[k]));

        // Full, then one return frees slot 1 for reuse.
        for (int i = 0; i < 4; i++) begin
            req(i + 4, MCN_W'({$urandom, $urandom}));
            step();
        end
        idle();
        repeat (2) step();
        chk("full_ready", wide_t'(bus.mem_req_i_ready), wide_t'(0));
        send(1, rnd_data());
        step();
        idle();
        step();
        chk("freed_ready", wide_t'(bus.mem_req_i_ready), wide_t'(1));
        req(9, 58'h3ff_0000);
        step();
        idle();
        repeat (2) step();
        chk("slot_reuse_tag", wide_t'(last_tag), wide_t'(1));
        drain();

        // Downstream and walker backpressure.
        bus.mrq_o_ready = 1'b0;
        req(7, MCN_W'({$urandom, $urandom}));
        step();
        req(8, MCN_W'({$urandom, $urandom}));
        repeat (5) step();
        chk("bp_ready", wide_t'(bus.mem_req_i_ready), wide_t'(0));
        bus.mrq_o_ready = 1'b1;
        step();
        idle();
        bus.mem_res_o_ready = 1'b0;
        repeat (2) step();
        send(mem_q[0], rnd_data());
        step();
        send(mem_q[0], rnd_data());
        step();
        bus.mrs_i_valid = 1'b0;
        repeat (3) step();
        chk("bp_res_held", wide_t'(bus.mem_res_o_valid), wide_t'(1));
        drain();

        // Response for a free slot.
        send(1, rnd_data());
        step();
        idle();
        step();
        chk("bad_tag_err", wide_t'(err_o), wide_t'(1));
        chk("bad_tag_no_res", wide_t'(bus.mem_res_o_valid), wide_t'(0));
        repeat (3) step();
        chk("err_sticky", wide_t'(err_o), wide_t'(1));

        // Reset with two requests outstanding, then a late response.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req(1, MCN_W'($urandom));
        step();
        req(2, MCN_W'($urandom));
        step();
        idle();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        send(0, rnd_data());
        step();
        idle();
        step();
        chk("late_err", wide_t'(err_o), wide_t'(1));
        chk("late_no_res", wide_t'(bus.mem_res_o_valid), wide_t'(0));
        chk("late_busy", wide_t'(busy_o), wide_t'(0));

        // Random traffic.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            bus.mem_req_i_valid    = ($urandom % 3) != 0;
            bus.mem_req_i_bits_idx = IDX_W'($urandom);
            bus.mem_req_i_bits_mcn = MCN_W'({$urandom, $urandom});
            bus.mrq_o_ready        = ($urandom % 4) != 0;
            bus.mem_res_o_ready    = ($urandom % 4) != 0;
            if (mem_q.size() > 0 && ($urandom % 2) == 1)
                send(mem_q[$urandom % mem_q.size()], rnd_data());
            else
                bus.mrs_i_valid = 1'b0;
            step();
        end
        drain();
        chk("random_no_err", wide_t'(err_o), wide_t'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
